frame_bank_writer: RTL and testbench
====================================

# frame_bank_writer

Write side of the ping-pong frame-bank scheme: once the mode FSM starts video playback, this block pulls compressed frame bytes from an upstream byte source. It expands them into 1-bit pixels and writes them into whichever bank the VGA side is not reading. It reports frame completion and flags underruns when the mode FSM swaps banks before a frame is fully written.

## Interface
Parameters:
- FRAME_PIXELS, 19200: pixels per frame (160x120); last written address is FRAME_PIXELS-1.
- ADDR_W, 15: width of wr_addr; must satisfy 2^ADDR_W >= FRAME_PIXELS.

Ports:
- CLK_40  in  1  system clock, 40 MHz.
- reset  in  1  synchronous, active-high.
- start_data_FSM  in  1  one-cycle pulse from the mode FSM marking playback start.
- switch_mode  in  1  one-cycle bank-swap pulse from the mode FSM.
- read_bank1  in  1  VGA side is reading bank 1.
- read_bank2  in  1  VGA side is reading bank 2.
- s_data  in  8  compressed byte from the upstream source.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  block accepts a byte this cycle.
- wr_addr  out  ADDR_W  pixel address within the bank.
- wr_data  out  1  pixel value (1 = white).
- wr_en_b1  out  1  write strobe for bank 1.
- wr_en_b2  out  1  write strobe for bank 2.
- frame_done  out  1  level; current frame fully written and waiting for a swap.
- underrun  out  1  sticky; a swap arrived before the frame was complete.
- frame_count  out  16  frames retired; wraps at 65535 -> 0.

## Operation
- States: IDLE, WAIT_BYTE, EXPAND, FRAME_DONE.
- IDLE: s_ready=0 and no writes. start_data_FSM moves the block to WAIT_BYTE with address 0. start_data_FSM is ignored in every state other than IDLE.
- WAIT_BYTE: s_ready=1. On s_valid&&s_ready the byte is latched, the run is loaded, and the block moves to EXPAND.
- Byte format with RLE_DECODE_EN: bit7 is the pixel value; bits6:0 are the run length minus 1, giving runs of 1..128.
- EXPAND: one pixel is written per cycle and wr_addr increments after each write. When the run is exhausted, the block returns to WAIT_BYTE.
- A write at FRAME_PIXELS-1 ends the frame in every case. Any remainder of the run is discarded, with no error. The block then moves to FRAME_DONE.
- Bank select is combinational on every write: wr_en_b1 = we & read_bank2, and wr_en_b2 = we & ~read_bank2. If neither read flag is set, writes go to bank 2.
- FRAME_DONE: s_ready=0 and frame_done=1. On switch_mode, frame_count increments, the address resets to 0, and the block moves to WAIT_BYTE.
- switch_mode in WAIT_BYTE or EXPAND sets underrun. The frame continues at its current address, which tears into the new write bank. frame_count is unchanged.
- If switch_mode lands on the same cycle as the final pixel write, it is not an underrun. frame_count increments, the address resets to 0, and the block goes directly to WAIT_BYTE without passing through FRAME_DONE.
- underrun is cleared only by reset.

## Timing
- Reset values: state IDLE, s_ready 0, wr_addr 0, wr_data 0, wr_en_b1 0, wr_en_b2 0, frame_done 0, underrun 0, frame_count 0.
- Reset mid-frame abandons the frame immediately, with no further writes.
- If a byte is accepted at edge N, its first write is in cycle N+1.
- A run of length L writes in cycles N+1 through N+L. s_ready reasserts in cycle N+L+1.
- Throughput is L pixels per L+1 cycles.
- wr_addr, wr_data, and the write strobes are registered and valid in the same cycle.
- frame_done rises in the cycle after the final write and falls in the cycle after the accepted switch_mode.
- underrun rises in the cycle after the offending switch_mode.

## Configuration
- RLE_DECODE_EN defined: input bytes are decoded as run-length bytes as described above.
- RLE_DECODE_EN undefined: each byte is 8 raw pixels, MSB first, and EXPAND always runs 8 cycles. Frame-end truncation still applies, and the unused low bits of the final byte are dropped.

## Test plan
- FRAME_PIXELS=16, RLE on, s_valid held high; after start, send 0x87 then 0x07. Addresses 0-7 must be written with data 1 and addresses 8-15 with data 0, all to bank 2 while read_bank1=1. frame_done must rise, and s_ready must be 0 in FRAME_DONE.
- From FRAME_DONE, pulse switch_mode with read_bank2=1. frame_count must become 1, and the next frame must be written to bank 1 starting at address 0.
- Pulse switch_mode after only 8 pixels of the frame are written. underrun must become 1 and stay 1, writes must continue at address 8, and frame_count must stay 0.
- Send 0xFF (run 128) with FRAME_PIXELS=16. Exactly 16 writes must occur, and then frame_done=1.
- Pulse switch_mode on the same cycle as the write to address 15. underrun must stay 0, frame_count must increment, and s_ready must be 1 on the next cycle.
- Assert reset during EXPAND. The next cycle must show no write strobes and all outputs at their reset values; with RLE off, byte 0xA5 must then write 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/frame_bank_writer.sv
// rtl/frame_bank_writer.sv - expands upstream bytes into 1-bit pixels for the bank not being displayed.
// Define RLE_DECODE_EN to decode run-length bytes; otherwise each byte is 8 raw pixels, MSB first.
module frame_bank_writer #(
  parameter int FRAME_PIXELS = 19200,
  parameter int ADDR_W       = 15
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic              start_data_FSM,
  input  logic              switch_mode,
  input  logic              read_bank1,
  input  logic              read_bank2,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              wr_en_b1,
  output logic              wr_en_b2,
  output logic              frame_done,
  output logic              underrun,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, EXPAND, FRAME_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  state_t            r_state;
  logic              r_s_ready;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_wr_data;
  logic              r_we;
  logic              r_frame_done;
  logic              r_underrun;
  logic [15:0]       r_frame_count;
  logic [6:0]        r_cnt;
`ifndef RLE_DECODE_EN
  logic [6:0]        r_shift;
`endif

  logic w_last_write;
  logic w_unused;

  // Bank choice follows the VGA read flags live; only bank 2 is written when neither flag is set.
  assign w_last_write = (r_state == EXPAND) && (r_wr_addr == LAST_ADDR);
  assign w_unused     = read_bank1;

  assign s_ready     = r_s_ready;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign wr_en_b1    = r_we & read_bank2;
  assign wr_en_b2    = r_we & ~read_bank2;
  assign frame_done  = r_frame_done;
  assign underrun    = r_underrun;
  assign frame_count = r_frame_count;

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_state       <= IDLE;
      r_s_ready     <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= 1'b0;
      r_we          <= 1'b0;
      r_frame_done  <= 1'b0;
      r_underrun    <= 1'b0;
      r_frame_count <= 16'd0;
      r_cnt         <= 7'd0;
`ifndef RLE_DECODE_EN
      r_shift       <= 7'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start_data_FSM) begin
            r_state   <= WAIT_BYTE;
            r_wr_addr <= '0;
            r_s_ready <= 1'b1;
          end
        end

        WAIT_BYTE: begin
          if (switch_mode) r_underrun <= 1'b1;
          if (s_valid) begin
            r_state   <= EXPAND;
            r_s_ready <= 1'b0;
            r_we      <= 1'b1;
            r_wr_data <= s_data[7];
`ifdef RLE_DECODE_EN
            r_cnt     <= s_data[6:0];
`else
            r_cnt     <= 7'd7;
            r_shift   <= s_data[6:0];
`endif
          end
        end

        EXPAND: begin
          if (w_last_write) begin
            // A swap coinciding with the final pixel retires the frame cleanly.
            r_we <= 1'b0;
            if (switch_mode) begin
              r_frame_count <= r_frame_count + 16'd1;
              r_wr_addr     <= '0;
              r_state       <= WAIT_BYTE;
              r_s_ready     <= 1'b1;
            end else begin
              r_state      <= FRAME_DONE;
              r_frame_done <= 1'b1;
            end
          end else begin
            if (switch_mode) r_underrun <= 1'b1;
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
            if (r_cnt == 7'd0) begin
              r_we      <= 1'b0;
              r_state   <= WAIT_BYTE;
              r_s_ready <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 7'd1;
`ifndef RLE_DECODE_EN
              r_wr_data <= r_shift[6];
              r_shift   <= {r_shift[5:0], 1'b0};
`endif
            end
          end
        end

        FRAME_DONE: begin
          if (switch_mode) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_wr_addr     <= '0;
            r_state       <= WAIT_BYTE;
            r_frame_done  <= 1'b0;
            r_s_ready     <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_bank_writer.sv
// tb/tb_frame_bank_writer.sv - randomized self-checking bench for frame_bank_writer with a pixel-list model.
module tb_frame_bank_writer;
  localparam int FP   = 16;
  localparam int AW   = 5;
  localparam int LAST = FP - 1;

  logic          CLK_40 = 1'b0;
  logic          reset = 1'b1;
  logic          start_data_FSM = 1'b0;
  logic          switch_mode = 1'b0;
  logic          read_bank1 = 1'b1;
  logic          read_bank2 = 1'b0;
  logic [7:0]    s_data = 8'd0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic          wr_en_b1;
  logic          wr_en_b2;
  logic          frame_done;
  logic          underrun;
  logic [15:0]   frame_count;

  frame_bank_writer #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
    .CLK_40(CLK_40), .reset(reset), .start_data_FSM(start_data_FSM),
    .switch_mode(switch_mode), .read_bank1(read_bank1), .read_bank2(read_bank2),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en_b1(wr_en_b1), .wr_en_b2(wr_en_b2),
    .frame_done(frame_done), .underrun(underrun), .frame_count(frame_count)
  );

  always #5 CLK_40 = ~CLK_40;

  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] exp_fc = 16'd0;

  int obs_addr[$];
  int obs_data[$];
  int obs_bank[$];
  logic [7:0] tx[$];
  int ex_addr[$];
  int ex_data[$];
  int ex_consumed;
  int ex_cost;
  int fed;
  int cyc;
  bit to;

  always @(negedge CLK_40) begin
    if (wr_en_b1 || wr_en_b2) begin
      obs_addr.push_back(int'(wr_addr));
      obs_data.push_back(int'(wr_data));
      obs_bank.push_back((wr_en_b1 && wr_en_b2) ? 3 : (wr_en_b1 ? 1 : 2));
    end
  end

  // Reference: the pixel list a byte sequence produces from a start address, cut at the frame end.
  task automatic model(input int start);
    int a;
    int written;
    logic [7:0] b;
    a = start;
    ex_addr.delete();
    ex_data.delete();
    ex_consumed = 0;
    ex_cost = 0;
    foreach (tx[i]) begin
      if (a >= FP) break;
      b = tx[i];
      written = 0;
      ex_consumed++;
`ifdef RLE_DECODE_EN
      for (int k = 0; k < int'(b[6:0]) + 1 && a < FP; k++) begin
        ex_addr.push_back(a); ex_data.push_back(int'(b[7])); a++; written++;
      end
`else
      for (int k = 7; k >= 0 && a < FP; k--) begin
        ex_addr.push_back(a); ex_data.push_back(int'(b[k])); a++; written++;
      end
`endif
      ex_cost += written + 1;
    end
  endtask

  task automatic gen_fill(input int start);
    int covered;
    logic [7:0] b;
    covered = start;
    foreach (tx[i]) begin
`ifdef RLE_DECODE_EN
      covered += int'(tx[i][6:0]) + 1;
`else
      covered += 8;
`endif
    end
    while (covered < FP) begin
`ifdef RLE_DECODE_EN
      b = {1'($urandom_range(0, 1)), 7'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 127 : 5))};
      covered += int'(b[6:0]) + 1;
`else
      b = 8'($urandom);
      covered += 8;
`endif
      tx.push_back(b);
    end
  endtask

  // Streams tx with s_valid held while bytes remain; stops at frame_done or when idle in WAIT_BYTE.
  task automatic feed(input bit swap_last);
    bit pending;
    int idx;
    idx = 0;
    pending = 1'b0;
    cyc = 0;
    to = 1'b1;
    obs_addr.delete(); obs_data.delete(); obs_bank.delete();
    while (cyc < 400) begin
      if (pending) idx++;
      if (frame_done || (idx == tx.size() && s_ready)) begin
        to = 1'b0;
        break;
      end
      s_valid = (idx < tx.size());
      s_data = s_valid ? tx[idx] : 8'd0;
      switch_mode = swap_last && (wr_en_b1 || wr_en_b2) && (int'(wr_addr) == LAST);
      pending = s_valid && s_ready;
      @(negedge CLK_40);
      cyc++;
    end
    s_valid = 1'b0;
    switch_mode = 1'b0;
    fed = idx;
    #1;
  endtask

  task automatic do_swap();
    switch_mode = 1'b1;
    @(negedge CLK_40);
    switch_mode = 1'b0;
    #1;
  endtask

  task automatic do_start();
    start_data_FSM = 1'b1;
    @(negedge CLK_40);
    start_data_FSM = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLK_40);
    reset = 1'b0;
    @(negedge CLK_40);
    #1;
    tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    tests_run++; if (wr_addr !== '0) begin tests_failed++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
    tests_run++; if (wr_data !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_data got %b want 0", wr_data); end
    tests_run++; if ({wr_en_b1, wr_en_b2} !== 2'b00) begin tests_failed++; $display("FAIL reset_wr_en got %b want 00", {wr_en_b1, wr_en_b2}); end
    tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    tests_run++; if (underrun !== 1'b0) begin tests_failed++; $display("FAIL reset_underrun got %b want 0", underrun); end
    tests_run++; if (frame_count !== 16'd0) begin tests_failed++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
  endtask

  task automatic test_first_frame();
    read_bank1 = 1'b1; read_bank2 = 1'b0;
    do_start();
    tx.delete(); tx.push_back(8'h87); tx.push_back(8'h07);
    model(0);
    feed(1'b0);
    tests_run++; if (to) begin tests_failed++; $display("FAIL first_timeout got timeout want frame_done"); end
    tests_run++; if (obs_addr.size() != ex_addr.size()) begin tests_failed++; $display("FAIL first_write_count got %0d want %0d", obs_addr.size(), ex_addr.size()); end
    for (int i = 0; i < ex_addr.size() && i < obs_addr.size(); i++) begin
      tests_run++;
      if (obs_addr[i] != ex_addr[i] || obs_data[i] != ex_data[i] || obs_bank[i] != 2) begin
        tests_failed++;
        $display("FAIL first_write[%0d] got a=%0d d=%0d bank=%0d want a=%0d d=%0d bank=2", i, obs_addr[i], obs_data[i], obs_bank[i], ex_addr[i], ex_data[i]);
      end
    end
    tests_run++; if (cyc != ex_cost) begin tests_failed++; $display("FAIL first_cycles got %0d want %0d", cyc, ex_cost); end
    tests_run++; if (frame_done !== 1'b1 || s_ready !== 1'b0) begin tests_failed++; $display("FAIL first_done got done=%b ready=%b want 1 0", frame_done, s_ready); end
  endtask

  task automatic test_swap();
    do_start();
    tests_run++; if (frame_done !== 1'b1 || s_ready !== 1'b0) begin tests_failed++; $display("FAIL start_ignored got done=%b ready=%b want 1 0", frame_done, s_ready); end
    for (int f = 0; f < 4; f++) begin
      int bank;
      if (f == 0) begin read_bank1 = 1'b0; read_bank2 = 1'b1; end
      else begin read_bank2 = 1'($urandom_range(0, 1)); read_bank1 = ~read_bank2; end
      bank = read_bank2 ? 1 : 2;
      do_swap();
      exp_fc = exp_fc + 16'd1;
      tests_run++; if (frame_count !== exp_fc || frame_done !== 1'b0 || s_ready !== 1'b1) begin
        tests_failed++; $display("FAIL swap_state[%0d] got fc=%0d done=%b ready=%b want fc=%0d 0 1", f, frame_count, frame_done, s_ready, exp_fc);
      end
      tx.delete(); gen_fill(0); model(0);
      feed(1'b0);
      tests_run++; if (obs_addr.size() != ex_addr.size() || to) begin tests_failed++; $display("FAIL swap_write_count[%0d] got %0d want %0d", f, obs_addr.size(), ex_addr.size()); end
      for (int i = 0; i < ex_addr.size() && i < obs_addr.size(); i++) begin
        tests_run++;
        if (obs_addr[i] != ex_addr[i] || obs_data[i] != ex_data[i] || obs_bank[i] != bank) begin
          tests_failed++;
          $display("FAIL swap_write[%0d][%0d] got a=%0d d=%0d bank=%0d want a=%0d d=%0d bank=%0d", f, i, obs_addr[i], obs_data[i], obs_bank[i], ex_addr[i], ex_data[i], bank);
        end
      end
      tests_run++; if (cyc != ex_cost || frame_done !== 1'b1) begin tests_failed++; $display("FAIL swap_cycles[%0d] got %0d done=%b want %0d done=1", f, cyc, frame_done, ex_cost); end
    end
  endtask

  task automatic test_truncate();
    read_bank1 = 1'b0; read_bank2 = 1'b0;
    do_swap();
    exp_fc = exp_fc + 16'd1;
    tx.delete(); tx.push_back(8'hFF); tx.push_back(8'hFF); tx.push_back(8'hFF);
    model(0);
    feed(1'b0);
    tests_run++; if (obs_addr.size() != FP || to) begin tests_failed++; $display("FAIL trunc_write_count got %0d want %0d", obs_addr.size(), FP); end
    for (int i = 0; i < FP && i < obs_addr.size(); i++) begin
      tests_run++;
      if (obs_addr[i] != i || obs_data[i] != ex_data[i] || obs_bank[i] != 2) begin
        tests_failed++; $display("FAIL trunc_write[%0d] got a=%0d d=%0d bank=%0d want a=%0d d=%0d bank=2", i, obs_addr[i], obs_data[i], obs_bank[i], i, ex_data[i]);
      end
    end
    tests_run++; if (fed != ex_consumed) begin tests_failed++; $display("FAIL trunc_bytes got %0d want %0d", fed, ex_consumed); end
    tests_run++; if (cyc != ex_cost || frame_done !== 1'b1 || underrun !== 1'b0) begin tests_failed++; $display("FAIL trunc_done got cyc=%0d done=%b ur=%b want %0d 1 0", cyc, frame_done, underrun, ex_cost); end
  endtask

  task automatic test_final_swap();
    int l1;
    do_swap();
    exp_fc = exp_fc + 16'd1;
    tx.delete();
`ifdef RLE_DECODE_EN
    l1 = $urandom_range(1, FP - 1);
    tx.push_back({1'($urandom_range(0, 1)), 7'(l1 - 1)});
    tx.push_back({1'($urandom_range(0, 1)), 7'(FP - l1 - 1)});
`else
    l1 = 0;
    tx.push_back(8'($urandom)); tx.push_back(8'($urandom));
`endif
    model(0);
    feed(1'b1);
    exp_fc = exp_fc + 16'd1;
    tests_run++; if (obs_addr.size() != ex_addr.size() || to) begin tests_failed++; $display("FAIL final_write_count got %0d want %0d (l1=%0d)", obs_addr.size(), ex_addr.size(), l1); end
    for (int i = 0; i < ex_addr.size() && i < obs_addr.size(); i++) begin
      tests_run++;
      if (obs_addr[i] != ex_addr[i] || obs_data[i] != ex_data[i]) begin
        tests_failed++; $display("FAIL final_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, obs_addr[i], obs_data[i], ex_addr[i], ex_data[i]);
      end
    end
    tests_run++; if (s_ready !== 1'b1 || frame_done !== 1'b0) begin tests_failed++; $display("FAIL final_ready got ready=%b done=%b want 1 0", s_ready, frame_done); end
    tests_run++; if (underrun !== 1'b0) begin tests_failed++; $display("FAIL final_underrun got %b want 0", underrun); end
    tests_run++; if (frame_count !== exp_fc) begin tests_failed++; $display("FAIL final_count got %0d want %0d", frame_count, exp_fc); end
  endtask

  task automatic test_underrun();
    read_bank1 = 1'b1; read_bank2 = 1'b0;
    tx.delete();
`ifdef RLE_DECODE_EN
    tx.push_back({1'($urandom_range(0, 1)), 7'd7});
`else
    tx.push_back(8'($urandom));
`endif
    model(0);
    feed(1'b0);
    tests_run++; if (obs_addr.size() != 8 || to || s_ready !== 1'b1) begin tests_failed++; $display("FAIL ur_half_count got %0d ready=%b want 8 1", obs_addr.size(), s_ready); end
    read_bank1 = 1'b0; read_bank2 = 1'b1;
    do_swap();
    tests_run++; if (underrun !== 1'b1) begin tests_failed++; $display("FAIL ur_set got %b want 1", underrun); end
    tests_run++; if (frame_count !== exp_fc) begin tests_failed++; $display("FAIL ur_count got %0d want %0d", frame_count, exp_fc); end
    tx.delete(); gen_fill(8); model(8);
    feed(1'b0);
    tests_run++; if (obs_addr.size() != ex_addr.size() || to) begin tests_failed++; $display("FAIL ur_rest_count got %0d want %0d", obs_addr.size(), ex_addr.size()); end
    for (int i = 0; i < ex_addr.size() && i < obs_addr.size(); i++) begin
      tests_run++;
      if (obs_addr[i] != ex_addr[i] || obs_data[i] != ex_data[i] || obs_bank[i] != 1) begin
        tests_failed++; $display("FAIL ur_write[%0d] got a=%0d d=%0d bank=%0d want a=%0d d=%0d bank=1", i, obs_addr[i], obs_data[i], obs_bank[i], ex_addr[i], ex_data[i]);
      end
    end
    tests_run++; if (frame_done !== 1'b1 || underrun !== 1'b1) begin tests_failed++; $display("FAIL ur_done got done=%b ur=%b want 1 1", frame_done, underrun); end
    do_swap();
    exp_fc = exp_fc + 16'd1;
    tests_run++; if (underrun !== 1'b1 || frame_count !== exp_fc) begin tests_failed++; $display("FAIL ur_sticky got ur=%b fc=%0d want 1 %0d", underrun, frame_count, exp_fc); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    s_valid = 1'b1; s_data = 8'hFF;
    @(negedge CLK_40);
    s_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK_40);
      seen = wr_en_b1 | wr_en_b2;
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL mid_expand got no write want write"); end
    reset = 1'b1;
    @(negedge CLK_40);
    #1;
    tests_run++; if ({wr_en_b1, wr_en_b2, s_ready, wr_data, frame_done, underrun} !== 6'd0 || wr_addr !== '0 || frame_count !== 16'd0) begin
      tests_failed++; $display("FAIL mid_reset got en=%b%b rdy=%b d=%b a=%0d done=%b ur=%b fc=%0d want all 0", wr_en_b1, wr_en_b2, s_ready, wr_data, wr_addr, frame_done, underrun, frame_count);
    end
    reset = 1'b0;
    exp_fc = 16'd0;
    @(negedge CLK_40);
    #1;
    tests_run++; if (s_ready !== 1'b0 || (wr_en_b1 | wr_en_b2) !== 1'b0) begin tests_failed++; $display("FAIL mid_idle got ready=%b we=%b want 0 0", s_ready, wr_en_b1 | wr_en_b2); end
    read_bank1 = 1'b1; read_bank2 = 1'b0;
    do_start();
    tx.delete(); tx.push_back(8'hA5); gen_fill(0); model(0);
    feed(1'b0);
    tests_run++; if (obs_addr.size() != ex_addr.size() || to) begin tests_failed++; $display("FAIL a5_count got %0d want %0d", obs_addr.size(), ex_addr.size()); end
    for (int i = 0; i < ex_addr.size() && i < obs_addr.size(); i++) begin
      tests_run++;
      if (obs_addr[i] != ex_addr[i] || obs_data[i] != ex_data[i] || obs_bank[i] != 2) begin
        tests_failed++; $display("FAIL a5_write[%0d] got a=%0d d=%0d bank=%0d want a=%0d d=%0d bank=2", i, obs_addr[i], obs_data[i], obs_bank[i], ex_addr[i], ex_data[i]);
      end
    end
    tests_run++; if (frame_done !== 1'b1 || frame_count !== exp_fc) begin tests_failed++; $display("FAIL a5_done got done=%b fc=%0d want 1 %0d", frame_done, frame_count, exp_fc); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_swap();
    test_truncate();
    test_final_swap();
    test_underrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
